inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Dual-issue instruction buffer between the fetch stage and id_stage.
- Accepts 0/1/2 fetched instructions per cycle into a circular FIFO.
- Presents the two oldest entries as the a/b slot inputs of id_stage.
- Retires 0/1/2 entries per cycle according to id_consume_inst. Flushed on redirect.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  discard all entries (branch mistaken / exception redirect)
- if_push_count  in  2  instructions offered this cycle: 0, 1 or 2
- if_a_pc, if_b_pc  in  32 each  PCs of the older/younger fetched instruction
- if_a_inst, if_b_inst  in  32 each  instruction words
- if_a_pred_branch_taken, if_b_pred_branch_taken  in  1 each  predictor direction
- if_a_pred_branch_target, if_b_pred_branch_target  in  32 each  predictor target
- if_a_have_exception, if_b_have_exception  in  1 each  fetch exception flag
- if_a_exception_type, if_b_exception_type  in  exception_t each  fetch exception code
- iq_ready  out  1  at least 2 free entries
- id_consume_inst  in  2  entries retired this cycle: 0, 1 or 2
- a_valid, b_valid  out  1 each  head / head+1 entry valid
- a_pc, a_inst, a_pred_branch_taken, a_pred_branch_target, a_have_exception, a_exception_type  out  as inputs  head entry
- b_pc, b_inst, b_pred_branch_taken, b_pred_branch_target, b_have_exception, b_exception_type  out  as inputs  head+1 entry
- iq_count  out  $clog2(DEPTH)+1  occupancy, for debug/perf

Behaviour:
- State: storage array of iq_entry_t[DEPTH]; head and tail pointers, $clog2(DEPTH) bits each, wrap mod DEPTH; count register.
- Reset: head=tail=count=0. Outputs after reset: a_valid=0, b_valid=0, iq_ready=1, iq_count=0. Storage contents are don't-care.
- Output timing:
  - a_valid = count>=1; b_valid = count>=2.
  - a_* = mem[head]; b_* = mem[head+1 mod DEPTH].
  - All outputs are combinational reads of registered state only. No input-to-output combinational path.
- iq_ready = (DEPTH - count) >= 2, computed from the registered count. It does not credit a same-cycle pop.
- Push, accepted only when iq_ready=1:
  - if_push_count=1: if_a_* is written at tail; tail += 1.
  - if_push_count=2: if_a_* at tail, if_b_* at tail+1; tail += 2. Program order a before b is preserved.
  - if_push_count=3, or any push while iq_ready=0: ignored, no state change.
- Pop:
  - eff_pop = min(id_consume_inst, count).
  - head += eff_pop. Consume requests beyond occupancy are clamped; 2'd3 is treated as 2 and then clamped.
- Simultaneous push and pop: count_next = count + eff_push - eff_pop. Both pointers update in the same cycle.
- Latency: an entry pushed in cycle N is visible on a_/b_ outputs in cycle N+1. There is no bypass from if_* to a_*/b_*.
- Flush:
  - Highest priority: head=tail=count=0 next cycle.
  - The same-cycle push and pop are both discarded.
  - Outputs in the flush cycle still reflect pre-flush state; id_stage masks them via its own consumption gating.
- Reset asserted mid-operation behaves as flush, plus the reset values above.
- Full boundary:
  - At count=DEPTH-2, iq_ready=1, and a push of 2 fills to DEPTH with no overwrite.
  - At count=DEPTH-1 or DEPTH, iq_ready=0.
- Wrap: a 2-wide push or pop crossing index DEPTH-1→0 wraps correctly.

Decomposition:
- Shared package (definitions.svh): typedef iq_entry_t, a packed struct {pc, inst, pred_branch_taken, pred_branch_target, have_exception, exception_type}. exception_t is reused.
- No sub-module. The storage array, pointers and count live in one always_ff; the read muxes are plain assigns.

Test Plan:
- Reset, then push 2 (pc 0x1c000000 and 0x1c000004) with consume 0 -> next cycle a_valid=b_valid=1, a_pc=0x1c000000, b_pc=0x1c000004, iq_count=2.
- Push 1 per cycle for 4 cycles while consuming 1 per cycle, starting from count=1 -> count stays 1; a_pc advances by 4 each cycle; order preserved.
- Fill to DEPTH-2=14, then push 2 -> count=16, iq_ready=0. A further push 2 is ignored: count stays 16 and the head entry is unchanged.
- count=1 with id_consume_inst=2 -> count=0, a_valid=0, head advances by 1 only.
- Pointer wrap: head=tail=15, push 2, then consume 2 -> entries are read from indices 15 and 0 in order; count returns to 0.
- count=5 with push 2, consume 1 and flush all in one cycle -> next cycle count=0, a_valid=0, iq_ready=1. The following push of 1 appears as a_* one cycle later.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// rtl/inst_queue_pkg.sv - shared types for the dual-issue instruction queue
package inst_queue_pkg;

   // Fetch-side exception codes carried alongside each instruction
   typedef enum logic [3:0] {
      EXC_NONE = 4'd0,
      EXC_ADEF = 4'd1,
      EXC_TLBR = 4'd2,
      EXC_PIF  = 4'd3,
      EXC_PPI  = 4'd4,
      EXC_INE  = 4'd5
   } exception_t;

   // One buffered instruction with its predictor and exception side info
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        pred_branch_taken;
      logic [31:0] pred_branch_target;
      logic        have_exception;
      exception_t  exception_type;
   } iq_entry_t;

   // A request of 3 is treated as 2: id_stage never retires more than two
   function automatic logic [1:0] sat_two(input logic [1:0] v);
      return (v == 2'd3) ? 2'd2 : v;
   endfunction

endpackage

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - circular dual-issue instruction buffer between fetch and id_stage
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush,
   input  logic [1:0]  if_push_count,
   input  logic [31:0] if_a_pc,
   input  logic [31:0] if_b_pc,
   input  logic [31:0] if_a_inst,
   input  logic [31:0] if_b_inst,
   input  logic        if_a_pred_branch_taken,
   input  logic        if_b_pred_branch_taken,
   input  logic [31:0] if_a_pred_branch_target,
   input  logic [31:0] if_b_pred_branch_target,
   input  logic        if_a_have_exception,
   input  logic        if_b_have_exception,
   input  exception_t  if_a_exception_type,
   input  exception_t  if_b_exception_type,
   output logic        iq_ready,
   input  logic [1:0]  id_consume_inst,
   output logic        a_valid,
   output logic        b_valid,
   output logic [31:0] a_pc,
   output logic [31:0] a_inst,
   output logic        a_pred_branch_taken,
   output logic [31:0] a_pred_branch_target,
   output logic        a_have_exception,
   output exception_t  a_exception_type,
   output logic [31:0] b_pc,
   output logic [31:0] b_inst,
   output logic        b_pred_branch_taken,
   output logic [31:0] b_pred_branch_target,
   output logic        b_have_exception,
   output exception_t  b_exception_type,
   output logic [$clog2(DEPTH):0] iq_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   iq_entry_t         mem [DEPTH];
   logic [PW-1:0]     head;
   logic [PW-1:0]     tail;
   logic [CW-1:0]     count;

   iq_entry_t         a_in;
   iq_entry_t         b_in;
   iq_entry_t         a_out;
   iq_entry_t         b_out;
   logic [PW-1:0]     head_p1;
   logic [PW-1:0]     tail_p1;
   logic [1:0]        eff_push;
   logic [1:0]        req_pop;
   logic [1:0]        eff_pop;

   assign a_in = '{pc: if_a_pc, inst: if_a_inst,
                   pred_branch_taken: if_a_pred_branch_taken,
                   pred_branch_target: if_a_pred_branch_target,
                   have_exception: if_a_have_exception,
                   exception_type: if_a_exception_type};
   assign b_in = '{pc: if_b_pc, inst: if_b_inst,
                   pred_branch_taken: if_b_pred_branch_taken,
                   pred_branch_target: if_b_pred_branch_target,
                   have_exception: if_b_have_exception,
                   exception_type: if_b_exception_type};

   // Ready only when two slots are free, judged from the registered count alone
   assign iq_ready = (count <= CW'(DEPTH - 2));

   assign head_p1 = head + PW'(1);
   assign tail_p1 = tail + PW'(1);

   // Accepted push width and occupancy-clamped pop width for this cycle
   always_comb begin
      eff_push = 2'd0;
      if (iq_ready && (if_push_count == 2'd1 || if_push_count == 2'd2))
         eff_push = if_push_count;
      req_pop = sat_two(id_consume_inst);
      eff_pop = req_pop;
      if (count < CW'(req_pop))
         eff_pop = count[1:0];
   end

   // Storage, pointers and occupancy; flush and reset drop everything including same-cycle traffic
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (eff_push != 2'd0)
            mem[tail] <= a_in;
         if (eff_push == 2'd2)
            mem[tail_p1] <= b_in;
         tail  <= tail + PW'(eff_push);
         head  <= head + PW'(eff_pop);
         count <= count + CW'(eff_push) - CW'(eff_pop);
      end
   end

   assign a_out = mem[head];
   assign b_out = mem[head_p1];

   assign a_valid              = (count >= CW'(1));
   assign b_valid              = (count >= CW'(2));
   assign iq_count             = count;

   assign a_pc                 = a_out.pc;
   assign a_inst               = a_out.inst;
   assign a_pred_branch_taken  = a_out.pred_branch_taken;
   assign a_pred_branch_target = a_out.pred_branch_target;
   assign a_have_exception     = a_out.have_exception;
   assign a_exception_type     = a_out.exception_type;

   assign b_pc                 = b_out.pc;
   assign b_inst               = b_out.inst;
   assign b_pred_branch_taken  = b_out.pred_branch_taken;
   assign b_pred_branch_target = b_out.pred_branch_target;
   assign b_have_exception     = b_out.have_exception;
   assign b_exception_type     = b_out.exception_type;

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized self-checking bench for inst_queue against a queue model
module tb_inst_queue;
   import inst_queue_pkg::*;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [1:0]  if_push_count;
   logic [1:0]  id_consume_inst;
   iq_entry_t   ea;
   iq_entry_t   eb;

   logic        iq_ready;
   logic        a_valid, b_valid;
   logic [31:0] a_pc, a_inst, a_pred_branch_target;
   logic [31:0] b_pc, b_inst, b_pred_branch_target;
   logic        a_pred_branch_taken, a_have_exception;
   logic        b_pred_branch_taken, b_have_exception;
   exception_t  a_exception_type, b_exception_type;
   logic [$clog2(DEPTH):0] iq_count;

   int total = 0;
   int bad   = 0;

   iq_entry_t mq[$];

   inst_queue #(.DEPTH(DEPTH)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .flush                   (flush),
      .if_push_count           (if_push_count),
      .if_a_pc                 (ea.pc),
      .if_b_pc                 (eb.pc),
      .if_a_inst               (ea.inst),
      .if_b_inst               (eb.inst),
      .if_a_pred_branch_taken  (ea.pred_branch_taken),
      .if_b_pred_branch_taken  (eb.pred_branch_taken),
      .if_a_pred_branch_target (ea.pred_branch_target),
      .if_b_pred_branch_target (eb.pred_branch_target),
      .if_a_have_exception     (ea.have_exception),
      .if_b_have_exception     (eb.have_exception),
      .if_a_exception_type     (ea.exception_type),
      .if_b_exception_type     (eb.exception_type),
      .iq_ready                (iq_ready),
      .id_consume_inst         (id_consume_inst),
      .a_valid                 (a_valid),
      .b_valid                 (b_valid),
      .a_pc                    (a_pc),
      .a_inst                  (a_inst),
      .a_pred_branch_taken     (a_pred_branch_taken),
      .a_pred_branch_target    (a_pred_branch_target),
      .a_have_exception        (a_have_exception),
      .a_exception_type        (a_exception_type),
      .b_pc                    (b_pc),
      .b_inst                  (b_inst),
      .b_pred_branch_taken     (b_pred_branch_taken),
      .b_pred_branch_target    (b_pred_branch_target),
      .b_have_exception        (b_have_exception),
      .b_exception_type        (b_exception_type),
      .iq_count                (iq_count)
   );

   always #5 clk = ~clk;

   // Hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, bad=%0d", bad);
      $fatal(1, "watchdog");
   end

   function automatic iq_entry_t rand_entry(input logic [31:0] pc);
      iq_entry_t e;
      e.pc                 = pc;
      e.inst               = $urandom;
      e.pred_branch_taken  = 1'($urandom_range(0, 1));
      e.pred_branch_target = $urandom;
      e.have_exception     = 1'($urandom_range(0, 1));
      e.exception_type     = exception_t'(4'($urandom_range(0, 5)));
      return e;
   endfunction

   // Drives one cycle of stimulus and advances the reference queue by the queue's rules
   task automatic drive_cycle(input logic rst, input logic fl, input logic [1:0] pcnt,
                              input logic [1:0] cons);
      int n;
      int pop;
      bit rdy;
      reset           = rst;
      flush           = fl;
      if_push_count   = pcnt;
      id_consume_inst = cons;
      @(posedge clk);
      if (rst || fl) begin
         mq.delete();
      end else begin
         n   = mq.size();
         rdy = (DEPTH - n) >= 2;
         pop = (cons == 2'd3) ? 2 : int'(cons);
         if (pop > n) pop = n;
         repeat (pop) void'(mq.pop_front());
         if (rdy && (pcnt == 2'd1 || pcnt == 2'd2)) mq.push_back(ea);
         if (rdy && pcnt == 2'd2) mq.push_back(eb);
      end
      #1;
      reset           = 1'b0;
      flush           = 1'b0;
      if_push_count   = 2'd0;
      id_consume_inst = 2'd0;
   endtask

   task automatic test_reset();
      ea = rand_entry(32'h0);
      eb = rand_entry(32'h0);
      drive_cycle(1'b1, 1'b0, 2'd2, 2'd0);
      drive_cycle(1'b1, 1'b0, 2'd0, 2'd0);
      total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid got=%b want=0", a_valid); end
      total++; if (b_valid !== 1'b0) begin bad++; $display("FAIL reset_b_valid got=%b want=0", b_valid); end
      total++; if (iq_ready !== 1'b1) begin bad++; $display("FAIL reset_iq_ready got=%b want=1", iq_ready); end
      total++; if (iq_count !== 5'd0) begin bad++; $display("FAIL reset_iq_count got=%0d want=0", iq_count); end
   endtask

   task automatic test_push_two();
      ea = rand_entry(32'h1c000000);
      eb = rand_entry(32'h1c000004);
      drive_cycle(1'b0, 1'b0, 2'd2, 2'd0);
      total++; if (a_valid !== 1'b1 || b_valid !== 1'b1) begin bad++; $display("FAIL push2_valid got=%b%b want=11", a_valid, b_valid); end
      total++; if (a_pc !== 32'h1c000000) begin bad++; $display("FAIL push2_a_pc got=%h want=1c000000", a_pc); end
      total++; if (b_pc !== 32'h1c000004) begin bad++; $display("FAIL push2_b_pc got=%h want=1c000004", b_pc); end
      total++; if (iq_count !== 5'd2) begin bad++; $display("FAIL push2_count got=%0d want=2", iq_count); end
      total++; if (a_inst !== ea.inst || b_inst !== eb.inst) begin bad++; $display("FAIL push2_inst got=%h/%h want=%h/%h", a_inst, b_inst, ea.inst, eb.inst); end
      total++; if (b_pred_branch_target !== eb.pred_branch_target || b_exception_type !== eb.exception_type)
         begin bad++; $display("FAIL push2_b_side got=%h/%0d want=%h/%0d", b_pred_branch_target, b_exception_type, eb.pred_branch_target, eb.exception_type); end
   endtask

   task automatic test_stream();
      drive_cycle(1'b0, 1'b0, 2'd0, 2'd1);
      total++; if (iq_count !== 5'd1 || a_pc !== 32'h1c000004) begin bad++; $display("FAIL stream_start got=%0d/%h want=1/1c000004", iq_count, a_pc); end
      for (int k = 0; k < 4; k++) begin
         ea = rand_entry(32'h1c000008 + 32'(4 * k));
         drive_cycle(1'b0, 1'b0, 2'd1, 2'd1);
         total++; if (iq_count !== 5'd1) begin bad++; $display("FAIL stream_count[%0d] got=%0d want=1", k, iq_count); end
         total++; if (a_pc !== 32'h1c000008 + 32'(4 * k)) begin bad++; $display("FAIL stream_a_pc[%0d] got=%h want=%h", k, a_pc, 32'h1c000008 + 32'(4 * k)); end
      end
   endtask

   task automatic test_full();
      logic [31:0] head_pc;
      drive_cycle(1'b0, 1'b1, 2'd0, 2'd0);
      for (int k = 0; k < 7; k++) begin
         ea = rand_entry(32'h2000 + 32'(8 * k));
         eb = rand_entry(32'h2004 + 32'(8 * k));
         drive_cycle(1'b0, 1'b0, 2'd2, 2'd0);
      end
      total++; if (iq_count !== 5'd14 || iq_ready !== 1'b1) begin bad++; $display("FAIL full_14 got=%0d/%b want=14/1", iq_count, iq_ready); end
      ea = rand_entry(32'h2038);
      eb = rand_entry(32'h203c);
      drive_cycle(1'b0, 1'b0, 2'd2, 2'd0);
      total++; if (iq_count !== 5'd16 || iq_ready !== 1'b0) begin bad++; $display("FAIL full_16 got=%0d/%b want=16/0", iq_count, iq_ready); end
      head_pc = 32'h2000;
      ea = rand_entry(32'hdead0000);
      eb = rand_entry(32'hdead0004);
      drive_cycle(1'b0, 1'b0, 2'd2, 2'd0);
      total++; if (iq_count !== 5'd16 || a_pc !== head_pc) begin bad++; $display("FAIL full_ignore got=%0d/%h want=16/%h", iq_count, a_pc, head_pc); end
      drive_cycle(1'b0, 1'b0, 2'd0, 2'd1);
      total++; if (iq_count !== 5'd15 || iq_ready !== 1'b0) begin bad++; $display("FAIL full_15 got=%0d/%b want=15/0", iq_count, iq_ready); end
      drive_cycle(1'b0, 1'b0, 2'd2, 2'd0);
      total++; if (iq_count !== 5'd15) begin bad++; $display("FAIL full_15_ignore got=%0d want=15", iq_count); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (a_valid !== (mq.size() >= 1) || (mq.size() >= 1 && a_pc !== mq[0].pc) ||
             (mq.size() >= 2 && b_pc !== mq[1].pc)) begin
            bad++; $display("FAIL full_drain[%0d] got=%b/%h/%h", k, a_valid, a_pc, b_pc);
         end
         drive_cycle(1'b0, 1'b0, 2'd0, 2'd2);
      end
      total++; if (iq_count !== 5'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL full_empty got=%0d/%b want=0/0", iq_count, a_valid); end
   endtask

   task automatic test_underflow();
      ea = rand_entry(32'h3000);
      drive_cycle(1'b0, 1'b0, 2'd1, 2'd0);
      drive_cycle(1'b0, 1'b0, 2'd0, 2'd2);
      total++; if (iq_count !== 5'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL under_clamp got=%0d/%b want=0/0", iq_count, a_valid); end
      ea = rand_entry(32'h3004);
      drive_cycle(1'b0, 1'b0, 2'd1, 2'd3);
      total++; if (iq_count !== 5'd1 || a_pc !== 32'h3004) begin bad++; $display("FAIL under_head got=%0d/%h want=1/3004", iq_count, a_pc); end
      drive_cycle(1'b0, 1'b0, 2'd0, 2'd3);
      total++; if (iq_count !== 5'd0) begin bad++; $display("FAIL under_three got=%0d want=0", iq_count); end
   endtask

   task automatic test_wrap();
      drive_cycle(1'b0, 1'b1, 2'd0, 2'd0);
      ea = rand_entry(32'h4000);
      drive_cycle(1'b0, 1'b0, 2'd1, 2'd0);
      for (int k = 1; k < 15; k++) begin
         ea = rand_entry(32'h4000 + 32'(4 * k));
         drive_cycle(1'b0, 1'b0, 2'd1, 2'd1);
      end
      drive_cycle(1'b0, 1'b0, 2'd0, 2'd1);
      total++; if (iq_count !== 5'd0) begin bad++; $display("FAIL wrap_setup got=%0d want=0", iq_count); end
      ea = rand_entry(32'h5000);
      eb = rand_entry(32'h5004);
      drive_cycle(1'b0, 1'b0, 2'd2, 2'd0);
      total++; if (a_pc !== 32'h5000 || b_pc !== 32'h5004) begin bad++; $display("FAIL wrap_read got=%h/%h want=5000/5004", a_pc, b_pc); end
      total++; if (a_inst !== ea.inst || b_inst !== eb.inst) begin bad++; $display("FAIL wrap_inst got=%h/%h want=%h/%h", a_inst, b_inst, ea.inst, eb.inst); end
      drive_cycle(1'b0, 1'b0, 2'd0, 2'd2);
      total++; if (iq_count !== 5'd0 || a_valid !== 1'b0) begin bad++; $display("FAIL wrap_drain got=%0d/%b want=0/0", iq_count, a_valid); end
   endtask

   task automatic test_flush();
      for (int k = 0; k < 5; k++) begin
         ea = rand_entry(32'h6000 + 32'(4 * k));
         drive_cycle(1'b0, 1'b0, 2'd1, 2'd0);
      end
      total++; if (iq_count !== 5'd5) begin bad++; $display("FAIL flush_setup got=%0d want=5", iq_count); end
      ea = rand_entry(32'h7000);
      eb = rand_entry(32'h7004);
      drive_cycle(1'b0, 1'b1, 2'd2, 2'd1);
      total++; if (iq_count !== 5'd0 || a_valid !== 1'b0 || iq_ready !== 1'b1)
         begin bad++; $display("FAIL flush_clear got=%0d/%b/%b want=0/0/1", iq_count, a_valid, iq_ready); end
      ea = rand_entry(32'h8000);
      drive_cycle(1'b0, 1'b0, 2'd1, 2'd0);
      total++; if (a_valid !== 1'b1 || a_pc !== 32'h8000 || b_valid !== 1'b0)
         begin bad++; $display("FAIL flush_refill got=%b/%h/%b want=1/8000/0", a_valid, a_pc, b_valid); end
   endtask

   task automatic test_random();
      logic rst, fl;
      for (int k = 0; k < 400; k++) begin
         ea  = rand_entry($urandom);
         eb  = rand_entry($urandom);
         rst = ($urandom_range(0, 99) == 0);
         fl  = ($urandom_range(0, 39) == 0);
         drive_cycle(rst, fl, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         total++;
         if (iq_count !== 5'(mq.size()) || iq_ready !== ((DEPTH - mq.size()) >= 2) ||
             a_valid !== (mq.size() >= 1) || b_valid !== (mq.size() >= 2)) begin
            bad++; $display("FAIL rand_state[%0d] got=%0d/%b/%b%b want=%0d", k, iq_count, iq_ready, a_valid, b_valid, mq.size());
         end
         if (mq.size() >= 1) begin
            total++;
            if ({a_pc, a_inst, a_pred_branch_taken, a_pred_branch_target, a_have_exception, a_exception_type} !== mq[0])
               begin bad++; $display("FAIL rand_a[%0d] got=%h want=%h", k, a_pc, mq[0].pc); end
         end
         if (mq.size() >= 2) begin
            total++;
            if ({b_pc, b_inst, b_pred_branch_taken, b_pred_branch_target, b_have_exception, b_exception_type} !== mq[1])
               begin bad++; $display("FAIL rand_b[%0d] got=%h want=%h", k, b_pc, mq[1].pc); end
         end
      end
   endtask

   initial begin
      reset           = 1'b1;
      flush           = 1'b0;
      if_push_count   = 2'd0;
      id_consume_inst = 2'd0;
      ea              = '0;
      eb              = '0;
      #2;
      test_reset();
      test_push_two();
      test_stream();
      test_full();
      test_underflow();
      test_wrap();
      test_flush();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
